// File: rtl/design67_pkg.sv
`default_nettype none
// ============================================================================
// Module      : design67_pkg
// Description : Shared widths and output field offsets for the design67
//               two-stage arithmetic datapath.
//               Contents:
//                 DATA_W  - operand width (8)
//                 ACC_W   - accumulator width (16, twice DATA_W)
//                 OUT_W   - packed output bus width (32)
//                 XOR_LSB, SUM_LSB, ACC_LSB - field offsets inside out
// Revision    : 1.0 - initial release
// ============================================================================
package design67_pkg;

    localparam int DATA_W  = 8;
    localparam int ACC_W   = 2 * DATA_W;
    localparam int OUT_W   = 32;

    localparam int XOR_LSB = 0;
    localparam int SUM_LSB = 8;
    localparam int ACC_LSB = 16;

endpackage : design67_pkg
`default_nettype wire

// File: rtl/design67_stage.sv
`default_nettype none
// ============================================================================
// Module      : design67_stage
// Description : Combinational stage-2 arithmetic on the current and previous
//               samples: bitwise XOR, modular sum and full-width product.
//               Ports:
//                 x_q  (in)  current sample
//                 x_d  (in)  previous sample
//                 xr   (out) x_q ^ x_d
//                 sum  (out) (x_q + x_d) mod 2**DATA_W, carry dropped
//                 prod (out) unsigned x_q * x_d, 2*DATA_W bits
// Revision    : 1.0 - initial release
// ============================================================================
module design67_stage
    import design67_pkg::*;
(
    input  logic [DATA_W-1:0] x_q,
    input  logic [DATA_W-1:0] x_d,
    output logic [DATA_W-1:0] xr,
    output logic [DATA_W-1:0] sum,
    output logic [ACC_W-1:0]  prod
);

    always_comb begin
        xr   = x_q ^ x_d;
        // Sum is evaluated in DATA_W context, so the carry falls off.
        sum  = x_q + x_d;
        // Zero-extend both operands so the product keeps all 16 bits.
        prod = {{(ACC_W-DATA_W){1'b0}}, x_q} * {{(ACC_W-DATA_W){1'b0}}, x_d};
    end

endmodule : design67_stage
`default_nettype wire

// File: rtl/design67_15_45.sv
`default_nettype none
// ============================================================================
// Module      : design67_15_45
// Description : Two-stage pipelined arithmetic datapath. Stage 1 captures
//               in[7:0] and keeps the previous sample; stage 2 registers the
//               XOR, modular sum and a wrapping product accumulator of the
//               two stage-1 values.
//               Ports:
//                 clk  (in)  rising-edge clock
//                 rst  (in)  asynchronous reset, active low
//                 in   (in)  32-bit stimulus, only in[7:0] is used
//                 out  (out) {acc[15:0], sum[7:0], xr[7:0]}, registered
// Revision    : 1.0 - initial release
// ============================================================================
module design67_15_45
    import design67_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OUT_W-1:0] in,
    output logic [OUT_W-1:0] out
);

    // Stage-1 registers
    logic [DATA_W-1:0] r_x_q;
    logic [DATA_W-1:0] r_x_d;

    // Stage-2 output registers
    logic [DATA_W-1:0] r_xr;
    logic [DATA_W-1:0] r_sum;
    logic [ACC_W-1:0]  r_acc;

    // Combinational stage-2 results
    logic [DATA_W-1:0] w_xr;
    logic [DATA_W-1:0] w_sum;
    logic [ACC_W-1:0]  w_prod;

    // The upper stimulus bits have no function; fold them into a sink so
    // the intent is explicit and nothing downstream can pick them up.
    logic w_unused_in;
    assign w_unused_in = ^in[OUT_W-1:DATA_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x_q <= '0;
            r_x_d <= '0;
        end else begin
            r_x_q <= in[DATA_W-1:0];
            r_x_d <= r_x_q;
        end
    end

    design67_stage u_stage (
        .x_q  (r_x_q),
        .x_d  (r_x_d),
        .xr   (w_xr),
        .sum  (w_sum),
        .prod (w_prod)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xr  <= '0;
            r_sum <= '0;
            r_acc <= '0;
        end else begin
            r_xr  <= w_xr;
            r_sum <= w_sum;
            // ACC_W-wide add: overflow past 16'hFFFF wraps silently.
            r_acc <= r_acc + w_prod;
        end
    end

    always_comb begin
        out                           = '0;
        out[XOR_LSB +: DATA_W]        = r_xr;
        out[SUM_LSB +: DATA_W]        = r_sum;
        out[ACC_LSB +: ACC_W]         = r_acc;
    end

endmodule : design67_15_45
`default_nettype wire

// File: tb/tb_design67_15_45.sv
`default_nettype none
// ============================================================================
// Module      : tb_design67_15_45
// Description : Self-checking bench for design67_15_45. A history of captured
//               samples since reset release is kept, and the expected output
//               after edge k is computed directly from that history.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_design67_15_45;

    logic        clk;
    logic        rst;
    logic [31:0] in_bus;
    logic [31:0] out_bus;

    int checks;
    int failures;

    // hist[0], hist[1] are the zeroed stage-1 values at release;
    // hist[k+1] is the byte captured on edge k after release.
    logic [7:0] hist[$];

    design67_15_45 dut (
        .clk (clk),
        .rst (rst),
        .in  (in_bus),
        .out (out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected out after edge k: fields from samples s[k-1], s[k-2];
    // accumulator is the sum of all pair products s[j-1]*s[j-2], j = 1..k.
    function automatic logic [31:0] model_out();
        int          k;
        logic [15:0] acc;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  xq;
        logic [7:0]  xd;
        logic [8:0]  s9;
        k   = hist.size() - 2;
        acc = 16'd0;
        for (int j = 1; j <= k; j++) begin
            a   = {8'd0, hist[j]};
            b   = {8'd0, hist[j-1]};
            acc = acc + a * b;
        end
        xq = hist[k];
        xd = hist[k-1];
        s9 = {1'b0, xq} + {1'b0, xd};
        return {acc, s9[7:0], xq ^ xd};
    endfunction

    task automatic tick(input logic [31:0] v);
        in_bus = v;
        @(posedge clk);
        #1;
        hist.push_back(v[7:0]);
    endtask

    task automatic start_run();
        rst = 1'b0;
        in_bus = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        hist.delete();
        hist.push_back(8'h00);
        hist.push_back(8'h00);
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        in_bus = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (out_bus !== 32'h0) begin
            $display("FAIL reset_async out=%h exp=%h", out_bus, 32'h0);
            failures++;
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_bus !== 32'h0) begin
                $display("FAIL reset_hold edge%0d out=%h exp=%h", i, out_bus, 32'h0);
                failures++;
            end
        end
        rst = 1'b1;
        hist.delete();
        hist.push_back(8'h00);
        hist.push_back(8'h00);
        tick(32'hFFFF_FFFF);
        checks++;
        if (out_bus !== 32'h0) begin
            $display("FAIL reset_release_first_edge out=%h exp=%h", out_bus, 32'h0);
            failures++;
        end
    endtask

    task automatic test_hold(input logic [31:0] v, input string name);
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h0000_0000;
        exp_tab[1] = 32'h0000_0303;
        exp_tab[2] = 32'h0009_0600;
        exp_tab[3] = 32'h0012_0600;
        start_run();
        for (int e = 0; e < 4; e++) begin
            tick(v);
            checks++;
            if (out_bus !== exp_tab[e]) begin
                $display("FAIL %s edge%0d out=%h exp=%h", name, e + 1, out_bus, exp_tab[e]);
                failures++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_tab [4];
        exp_tab[0] = 32'h0000_0000;
        exp_tab[1] = 32'h0000_FFFF;
        exp_tab[2] = 32'hFE01_FE00;
        exp_tab[3] = 32'hFC02_FE00;
        start_run();
        for (int e = 0; e < 4; e++) begin
            tick(32'h0000_00FF);
            checks++;
            if (out_bus !== exp_tab[e]) begin
                $display("FAIL wrap edge%0d out=%h exp=%h", e + 1, out_bus, exp_tab[e]);
                failures++;
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] exp;
        start_run();
        for (int e = 0; e < 3; e++) tick(32'h0000_00FF);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_bus !== 32'h0) begin
            $display("FAIL async_reset_mid out=%h exp=%h", out_bus, 32'h0);
            failures++;
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        hist.delete();
        hist.push_back(8'h00);
        hist.push_back(8'h00);
        for (int e = 0; e < 4; e++) begin
            tick(32'h0000_00FF);
            exp = model_out();
            checks++;
            if (out_bus !== exp) begin
                $display("FAIL async_restart edge%0d out=%h exp=%h", e + 1, out_bus, exp);
                failures++;
            end
        end
        checks++;
        if (out_bus !== 32'hFC02_FE00) begin
            $display("FAIL async_restart_acc out=%h exp=%h", out_bus, 32'hFC02_FE00);
            failures++;
        end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [31:0] exp;
        int          errs;
        errs = 0;
        start_run();
        for (int n = 0; n < 1000; n++) begin
            v = $urandom;
            for (int h = 0; h < 2; h++) begin
                tick(v);
                exp = model_out();
                checks++;
                if (out_bus !== exp) begin
                    if (errs < 10)
                        $display("FAIL random n=%0d h=%0d in=%h out=%h exp=%h",
                                 n, h, v, out_bus, exp);
                    errs++;
                    failures++;
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_bus   = 32'h0;
        @(negedge clk);
        test_reset();
        test_hold(32'h0000_0003, "hold03");
        test_hold(32'hABCD_EF03, "upper_ignored");
        test_wrap();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_design67_15_45
`default_nettype wire

// File: doc/design67_15_45.md
# design67_15_45

Small two-stage pipelined arithmetic datapath. It samples an 8-bit operand every cycle and emits a packed 32-bit result: bitwise XOR, modular sum and a wrapping product accumulator of the current and previous samples. It is a self-contained leaf benchmark block and is checked cycle-for-cycle against its post-route netlist.

## Interface
- DATA_W, 8, operand width taken from `in`.
- ACC_W, 16, accumulator width; equals 2*DATA_W.
- OUT_W, 32, output bus width.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: reset, asynchronous, active-low (0 = reset asserted).
- `in` input, 32 bits: stimulus bus. Only `in[7:0]` is used; `in[31:8]` is ignored and must not affect any state.
- `out` output, 32 bits: registered result, packed as {acc[15:0], sum[7:0], xr[7:0]}.

## Operation
- Stage 1 registers:
  - `x_q <= in[7:0]`
  - `x_d <= x_q` (the previous sample)
- Stage 2 output registers, computed from the stage-1 register values before the edge:
  - `out[7:0] <= x_q ^ x_d`
  - `out[15:8] <= (x_q + x_d) mod 256`; the carry is discarded.
  - `out[31:16] <= (out[31:16] + x_q * x_d) mod 65536`. The product is unsigned 8x8 -> 16 bits, and the accumulator wraps silently.
- All arithmetic is unsigned. There are no saturation, overflow or status flags.
- While `rst`=0, the following are forced to 0 immediately, independent of `clk`:
  - `x_q`, `x_d`
  - all of `out`
- While `rst`=0, edges of `clk` have no effect.
- After reset is released, the accumulator restarts from 0.

## Timing
- Latency from input to output:
  - A value on `in[7:0]` captured at rising edge N appears in the XOR and sum fields after edge N+1.
  - Paired with its successor (as `x_d`), it contributes again after edge N+2.
  - A stimulus held for two cycles is therefore fully reflected two edges after it is applied.
- Throughput: one sample per cycle; there is no handshake and no stall.
- Reset values: `out` = 32'h0000_0000, `x_q` = 0, `x_d` = 0.
- Reset assertion takes effect asynchronously, including mid-operation between edges.
- Reset release is synchronous to the next rising edge. The first edge after release captures `in[7:0]` into `x_q` and computes `out` from zeroed stage-1 registers, so `out` stays 0 on that edge.
- Accumulator wrap: exceeding 16'hFFFF drops bit 16 with no indication.

## Structure
- Shared package `design67_pkg`:
  - Constants DATA_W=8, ACC_W=16, OUT_W=32.
  - Field offsets XOR_LSB=0, SUM_LSB=8, ACC_LSB=16.
- Natural sub-module `design67_stage`:
  - Inputs: `x_q` and `x_d`.
  - Outputs: the combinational XOR, sum and product.
- The top-level module holds:
  - the stage-1 registers;
  - the output/accumulator register with async active-low clear;
  - the output packing.

## Test plan
- Reset:
  - Hold `rst`=0 with `in`=32'hFFFF_FFFF for 3 edges -> `out` = 0 throughout.
  - Release `rst`; `out` stays 0 on the first edge after release, because `out` is computed from zeroed stage-1 registers.
- Hold `in`=32'h03 from reset release, counting edges after release:
  - edge 1: `out` = 32'h0000_0000
  - edge 2: `out` = 32'h0000_0303
  - edge 3: `out` = 32'h0009_0600
  - edge 4: `out` = 32'h0012_0600
- Upper bits ignored: in a fresh run from reset, the sequence with `in`=32'hABCD_EF03 is identical edge-for-edge to the `in`=32'h03 sequence.
- Wrap: hold `in`=8'hFF after reset, counting edges after release:
  - sum field = 8'hFE
  - product = 16'hFE01
  - edge 3: `out` = 32'hFE01_FE00
  - edge 4: `out` = 32'hFC02_FE00 (accumulator wrapped)
- Asynchronous reset mid-run: during the 8'hFF run, drive `rst`=0 between edges -> `out` = 0 before the next edge. On release, the accumulator restarts from 0.
- Random regression: 1000 random 32-bit `in` values, each held 2 cycles. `out` must match a software model of the equations above every cycle, with zero mismatches.
